// File: rtl/dram_accum_bank_ctrl.sv
// Banked word memory with read / write / accumulate commands.
// Two-stage pipeline: stage 1 accepts a command and reads the memory into a
// register, and stage 2 computes the new value and writes it back. Stage-2
// results are forwarded into stage 1, so dependent commands see the newest
// data at full rate. Overflow is reported as a pulse and as a sticky flag per bank.
module dram_accum_bank_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int NUM_BANKS  = 4,
    parameter bit SAT_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ACC_WIDTH-1:0]  cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ovf_pulse,
    output logic [NUM_BANKS-1:0]  ovf_sticky,
    input  logic [NUM_BANKS-1:0]  ovf_clr,
    output logic                  err_illegal
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int SW    = ACC_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] BANK_MASK = ADDR_WIDTH'(NUM_BANKS - 1);
    localparam logic signed [SW-1:0]  MAXV = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0]  MINV = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_ACC = 2'b10,
        OP_ILL = 2'b11
    } op_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  r_s2_vld;
    op_t                   r_s2_op;
    logic [ADDR_WIDTH-1:0] r_s2_addr;
    logic [ACC_WIDTH-1:0]  r_s2_data;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [NUM_BANKS-1:0]  r_sticky;

    logic                  w_accept;
    logic signed [SW-1:0]  w_old_ext;
    logic signed [SW-1:0]  w_opd_ext;
    logic signed [SW-1:0]  w_sum;
    logic                  w_pos_ovf;
    logic                  w_neg_ovf;
    logic                  w_ovf;
    logic [DATA_WIDTH-1:0] w_acc_val;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_val;
    logic [DATA_WIDTH-1:0] w_rd_val;
    logic [NUM_BANKS-1:0]  w_set;

    // Held responses freeze the whole pipeline; reset also forces the handshake low.
    assign cmd_ready   = rst_n & ~(rsp_valid & ~rsp_ready);
    assign w_accept    = cmd_valid & cmd_ready;

    assign rsp_valid   = r_s2_vld && (r_s2_op == OP_RD);
    assign rsp_data    = r_rd_data;
    assign err_illegal = r_s2_vld && (r_s2_op == OP_ILL);
    assign ovf_sticky  = r_sticky;

    // Full-precision sum: ACC_WIDTH+1 bits cannot overflow for any operand pair.
    assign w_old_ext = SW'($signed(r_rd_data));
    assign w_opd_ext = SW'($signed(r_s2_data));
    assign w_sum     = w_old_ext + w_opd_ext;
    assign w_pos_ovf = w_sum > MAXV;
    assign w_neg_ovf = w_sum < MINV;
    assign w_ovf     = w_pos_ovf | w_neg_ovf;
    assign w_acc_val = (SAT_EN && w_pos_ovf) ? SAT_MAX :
                       (SAT_EN && w_neg_ovf) ? SAT_MIN : w_sum[DATA_WIDTH-1:0];

    assign ovf_pulse = r_s2_vld && (r_s2_op == OP_ACC) && w_ovf;

    // Stage-2 write decode: only writes and accumulates touch memory.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_val = r_s2_data[DATA_WIDTH-1:0];
        case (r_s2_op)
            OP_WR:   w_wr_en = r_s2_vld;
            OP_ACC: begin
                w_wr_en  = r_s2_vld;
                w_wr_val = w_acc_val;
            end
            default: w_wr_en = 1'b0;
        endcase
    end

    // Stage-1 read data, bypassing the memory when stage 2 is writing the same word.
    assign w_rd_val = (w_wr_en && (r_s2_addr == cmd_addr)) ? w_wr_val : r_mem[cmd_addr];

    // Memory write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_s2_addr] <= w_wr_val;
    end

    // Stage-1 to stage-2 pipeline register; holds while a response is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_op   <= OP_RD;
            r_s2_addr <= '0;
            r_s2_data <= '0;
            r_rd_data <= '0;
        end else if (cmd_ready) begin
            r_s2_vld <= cmd_valid;
            if (w_accept) begin
                r_s2_op   <= op_t'(cmd_op);
                r_s2_addr <= cmd_addr;
                r_s2_data <= cmd_data;
                r_rd_data <= w_rd_val;
            end
        end
    end

    // One-hot bank select for the overflow being reported this cycle.
    always_comb begin
        w_set = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            w_set[b] = ovf_pulse && ((r_s2_addr & BANK_MASK) == ADDR_WIDTH'(b));
    end

    // Sticky overflow flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sticky <= '0;
        else        r_sticky <= (r_sticky & ~ovf_clr) | w_set;
    end

endmodule
